pipe_ctrl: RTL and testbench

Pipeline control unit for the 5-stage RISC-V core. It consumes the hazard stall request, the EX-stage branch-taken flag and the data-memory busy flag, and turns them into per-stage register enables and flush (bubble) controls. Unlike the hazard detector, it is the enforcing side of the stall contract. It remembers a branch that resolves while the pipeline is frozen, watches for livelocked stalls, and optionally counts stall, flush and freeze events. It sits between the hazard/branch logic and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

---
 rtl/pipe_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: per-stage enables/flushes from stall, branch and memory-busy requests.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_ctrl #(
  parameter int STALL_TIMEOUT = 16,
  parameter int CNT_W         = 32
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_stall_req,
  input  logic             i_branch_taken,
  input  logic             i_mem_busy,
  output logic             o_pc_en,
  output logic             o_fd_en,
  output logic             o_de_en,
  output logic             o_em_en,
  output logic             o_mw_en,
  output logic             o_fd_flush,
  output logic             o_de_flush,
  output logic [1:0]       o_mode,
  output logic             o_haz_err
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_count,
  output logic [CNT_W-1:0] o_freeze_cycles
`endif
);

  typedef enum logic [1:0] {
    A_RUN    = 2'd0,
    A_HAZARD = 2'd1,
    A_FLUSH  = 2'd2,
    A_FREEZE = 2'd3
  } action_t;

  localparam logic [7:0] TIMEOUT8 = 8'(STALL_TIMEOUT);

  action_t    r_mode;
  action_t    w_action;
  logic       r_br_pend;
  logic [7:0] r_hcnt;
  logic [7:0] w_hcnt_inc;
  logic       r_haz_err;

  always_comb begin
    w_action   = A_RUN;
    o_pc_en    = 1'b1;
    o_fd_en    = 1'b1;
    o_de_en    = 1'b1;
    o_em_en    = 1'b1;
    o_mw_en    = 1'b1;
    o_fd_flush = 1'b0;
    o_de_flush = 1'b0;
    if (i_mem_busy)
      w_action = A_FREEZE;
    else if (i_branch_taken || r_br_pend)
      w_action = A_FLUSH;
    else if (i_stall_req)
      w_action = A_HAZARD;
    case (w_action)
      A_FREEZE: begin
        o_pc_en = 1'b0;
        o_fd_en = 1'b0;
        o_de_en = 1'b0;
        o_em_en = 1'b0;
        o_mw_en = 1'b0;
      end
      A_FLUSH: begin
        o_fd_flush = 1'b1;
        o_de_flush = 1'b1;
      end
      A_HAZARD: begin
        o_pc_en    = 1'b0;
        o_fd_en    = 1'b0;
        o_de_flush = 1'b1;
      end
      default: ;
    endcase
    // Reset overrides everything: hold all registers and force bubbles.
    if (!i_rstn) begin
      o_pc_en    = 1'b0;
      o_fd_en    = 1'b0;
      o_de_en    = 1'b0;
      o_em_en    = 1'b0;
      o_mw_en    = 1'b0;
      o_fd_flush = 1'b1;
      o_de_flush = 1'b1;
    end
  end

  assign w_hcnt_inc = (r_hcnt == 8'hFF) ? r_hcnt : r_hcnt + 8'd1;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_mode    <= A_RUN;
      r_br_pend <= 1'b0;
      r_hcnt    <= 8'd0;
      r_haz_err <= 1'b0;
    end else begin
      r_mode <= w_action;
      if (w_action == A_FREEZE && i_branch_taken)
        r_br_pend <= 1'b1;
      else if (w_action == A_FLUSH)
        r_br_pend <= 1'b0;
      // Freeze cycles hold the watchdog so a memory stall does not mask a livelock.
      case (w_action)
        A_HAZARD: begin
          r_hcnt <= w_hcnt_inc;
          if (w_hcnt_inc >= TIMEOUT8)
            r_haz_err <= 1'b1;
        end
        A_FREEZE: r_hcnt <= r_hcnt;
        default:  r_hcnt <= 8'd0;
      endcase
    end
  end

  assign o_mode    = r_mode;
  assign o_haz_err = r_haz_err;

`ifdef PIPE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;
  logic [CNT_W-1:0] r_freeze_cycles;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_stall_cycles  <= '0;
      r_flush_count   <= '0;
      r_freeze_cycles <= '0;
    end else begin
      if (w_action == A_HAZARD && r_stall_cycles != CNT_MAX)
        r_stall_cycles <= r_stall_cycles + 1'b1;
      if (w_action == A_FLUSH && r_flush_count != CNT_MAX)
        r_flush_count <= r_flush_count + 1'b1;
      if (w_action == A_FREEZE && r_freeze_cycles != CNT_MAX)
        r_freeze_cycles <= r_freeze_cycles + 1'b1;
    end
  end

  assign o_stall_cycles  = r_stall_cycles;
  assign o_flush_count   = r_flush_count;
  assign o_freeze_cycles = r_freeze_cycles;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic against a cycle model.
module tb_pipe_ctrl;
  localparam int TO    = 16;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rstn, stall, br, busy;
  logic pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, haz_err;
  logic [1:0] mode;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles, flush_count, freeze_cycles;
`endif

  always #5 clk = ~clk;

  pipe_ctrl #(.STALL_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_stall_req(stall), .i_branch_taken(br), .i_mem_busy(busy),
    .o_pc_en(pc_en), .o_fd_en(fd_en), .o_de_en(de_en), .o_em_en(em_en), .o_mw_en(mw_en),
    .o_fd_flush(fd_flush), .o_de_flush(de_flush), .o_mode(mode), .o_haz_err(haz_err)
`ifdef PIPE_PERF_CNT_EN
    , .o_stall_cycles(stall_cycles), .o_flush_count(flush_count), .o_freeze_cycles(freeze_cycles)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit     m_pend;
  int     m_run;      // length of current hazard run (freeze cycles do not break it)
  bit     m_err;
  int     m_mode;
  longint m_stall_c, m_flush_c, m_freeze_c;
  localparam longint CMAX = (64'd1 << CNT_W) - 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] ctrl_vec();
    return {pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush};
  endfunction

  task automatic model_reset();
    m_pend = 0; m_run = 0; m_err = 0; m_mode = 0;
    m_stall_c = 0; m_flush_c = 0; m_freeze_c = 0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".mode"}, 64'(mode), 64'(m_mode));
    chk({tag, ".haz_err"}, 64'(haz_err), 64'(m_err));
`ifdef PIPE_PERF_CNT_EN
    chk({tag, ".stall_cycles"}, 64'(stall_cycles), 64'(m_stall_c));
    chk({tag, ".flush_count"}, 64'(flush_count), 64'(m_flush_c));
    chk({tag, ".freeze_cycles"}, 64'(freeze_cycles), 64'(m_freeze_c));
`endif
  endtask

  // One clock cycle: apply inputs, check combinational controls, clock, check registered state.
  task automatic step(input string tag, input bit s, input bit b, input bit m);
    int act;
    logic [6:0] exp;
    stall = s; br = b; busy = m;
    if (m)                act = 3;
    else if (b || m_pend) act = 2;
    else if (s)           act = 1;
    else                  act = 0;
    case (act)
      3:       exp = 7'b00000_00;
      2:       exp = 7'b11111_11;
      1:       exp = 7'b00111_01;
      default: exp = 7'b11111_00;
    endcase
    #2;
    chk({tag, ".ctrl"}, 64'(ctrl_vec()), 64'(exp));
    @(posedge clk);
    m_mode = act;
    if (act == 3 && b) m_pend = 1;
    if (act == 2)      m_pend = 0;
    if (act == 1) begin
      m_run++;
      if (m_run >= TO) m_err = 1;
      if (m_stall_c < CMAX) m_stall_c++;
    end else if (act == 3) begin
      if (m_freeze_c < CMAX) m_freeze_c++;
    end else begin
      m_run = 0;
      if (act == 2 && m_flush_c < CMAX) m_flush_c++;
    end
    #1;
    check_regs(tag);
    $display("[TB] %s stall=%0b br=%0b busy=%0b mode=%0d haz_err=%0b", tag, s, b, m, mode, haz_err);
  endtask

  task automatic do_reset(input string tag);
    rstn = 1'b0;
    stall = 1'($urandom); br = 1'($urandom); busy = 1'($urandom);
    model_reset();
    #2;
    chk({tag, ".rst_ctrl"}, 64'(ctrl_vec()), 64'(7'b00000_11));
    check_regs({tag, ".rst"});
    @(posedge clk);
    #1;
    chk({tag, ".rst_ctrl_hold"}, 64'(ctrl_vec()), 64'(7'b00000_11));
    stall = 0; br = 0; busy = 0;
    rstn = 1'b1;
    $display("[TB] %s reset released", tag);
  endtask

  initial begin
    rstn = 1'b0; stall = 0; br = 0; busy = 0;
    model_reset();
    @(posedge clk); #1;

    do_reset("reset");
    step("run0", 0, 0, 0);

    // load-use hazard
    step("lu1", 1, 0, 0);
    step("lu2", 1, 0, 0);
    step("lu_end", 0, 0, 0);

    // branch over stall
    step("br_over_stall", 1, 1, 0);
    step("after_br", 0, 0, 0);

    // branch during freeze (pulsed in 2nd freeze cycle)
    step("frz1", 0, 0, 1);
    step("frz2_br", 0, 1, 1);
    step("frz3", 0, 0, 1);
    step("frz_flush", 0, 0, 0);
    chk("frz_flush.mode_is_flush", 64'(mode), 64'd2);
    step("frz_run", 0, 0, 0);
    chk("frz_run.mode_is_run", 64'(mode), 64'd0);

    // branch held across freeze, new branch on release: single flush
    step("frzh1", 0, 1, 1);
    step("frzh2", 0, 1, 1);
    step("frzh_new_br", 0, 1, 0);
    step("frzh_run", 0, 0, 0);

    // watchdog: 15 hazard cycles -> no error, 16th -> error, sticky
    for (int i = 0; i < 15; i++) step($sformatf("wd%0d", i + 1), 1, 0, 0);
    chk("wd15.no_err", 64'(haz_err), 64'd0);
    step("wd16", 1, 0, 0);
    chk("wd16.err", 64'(haz_err), 64'd1);
    step("wd_sticky", 0, 0, 0);
    chk("wd_sticky.err", 64'(haz_err), 64'd1);

    // watchdog broken by a RUN cycle
    do_reset("reset2");
    for (int i = 0; i < 10; i++) step($sformatf("wdr_a%0d", i), 1, 0, 0);
    step("wdr_run", 0, 0, 0);
    for (int i = 0; i < 10; i++) step($sformatf("wdr_b%0d", i), 1, 0, 0);
    chk("wdr.no_err", 64'(haz_err), 64'd0);

    // watchdog not broken by a FREEZE cycle
    do_reset("reset3");
    for (int i = 0; i < 10; i++) step($sformatf("wdf_a%0d", i), 1, 0, 0);
    step("wdf_freeze", 1, 0, 1);
    for (int i = 0; i < 5; i++) step($sformatf("wdf_b%0d", i), 1, 0, 0);
    chk("wdf15.no_err", 64'(haz_err), 64'd0);
    step("wdf_16th", 1, 0, 0);
    chk("wdf16.err", 64'(haz_err), 64'd1);

    // reset released mid-freeze with a pending branch: no flush afterwards
    do_reset("reset4");
    step("rf_frz", 0, 1, 1);
    do_reset("reset_mid_frz");
    step("rf_after", 0, 0, 0);
    chk("rf_after.mode_run", 64'(mode), 64'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step($sformatf("rnd%0d", i),
           $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 25);
      if ($urandom_range(0, 99) == 0) do_reset($sformatf("rnd_rst%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
